// File: rtl/vec_mem_stage.sv
// vec_mem_stage: memory stage of the vector ASIP pipeline.
// Takes one op per in_valid/in_ready handshake. An op is a pass-through, a vector load
// or a vector store. A bus op moves the VEC_W-bit vector as BEATS ack-handshaked beats of
// BEAT_W bits, least significant beat first. A store whose base is at or above GPIO_BASE
// writes the GPIO register instead of the bus. The result is returned on out_valid/out_ready.
module vec_mem_stage #(
  parameter int unsigned LANES     = 16,
  parameter int unsigned LANE_W    = 8,
  parameter int unsigned BEAT_W    = 32,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned GPIO_BASE = 'hFF00,
  parameter int unsigned GPIO_CH   = 4,
  parameter int unsigned GPIO_W    = 32,
  localparam int unsigned VEC_W    = LANES * LANE_W,
  localparam int unsigned BEATS    = VEC_W / BEAT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  // op input
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               rmem,
  input  logic               wmem,
  input  logic [VEC_W-1:0]   alu_res,
  input  logic [VEC_W-1:0]   store_data,
  // result output
  output logic               out_valid,
  input  logic               out_ready,
  output logic [VEC_W-1:0]   res,
  // beat-level memory bus
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BEAT_W-1:0]  mem_wdata,
  input  logic               mem_ack,
  input  logic [BEAT_W-1:0]  mem_rdata,
  // memory-mapped GPIO
  output logic [GPIO_W-1:0]  gpio,
  output logic [GPIO_CH-1:0] gpio_en
);

  localparam int unsigned KW = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [KW-1:0]     LAST_K      = KW'(BEATS - 1);
  localparam logic [ADDR_W-1:0] GPIO_BASE_A = ADDR_W'(GPIO_BASE);
  localparam logic [ADDR_W-1:0] GPIO_CH_A   = ADDR_W'(GPIO_CH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]         state_q,   state_d;
  logic [ADDR_W-1:0]  base_q,    base_d;
  logic [VEC_W-1:0]   alu_q,     alu_d;
  logic [VEC_W-1:0]   sdata_q,   sdata_d;
  logic               store_q,   store_d;
  logic [KW-1:0]      k_q,       k_d;
  logic [VEC_W-1:0]   buf_q,     buf_d;
  logic [VEC_W-1:0]   res_q,     res_d;
  logic [GPIO_W-1:0]  gpio_q,    gpio_d;
  logic [GPIO_CH-1:0] gpio_en_q, gpio_en_d;

  logic              accept;
  logic [ADDR_W-1:0] in_base;
  logic              in_mmio;
  logic [ADDR_W-1:0] gpio_ch;
  logic              ch_ok;
  logic              in_xfer;
  logic              last_beat;

  // Decode the presented op. The MMIO decision looks at the base address only.
  always_comb begin
    accept    = in_valid & in_ready;
    in_base   = alu_res[ADDR_W-1:0];
    in_mmio   = (in_base >= GPIO_BASE_A);
    gpio_ch   = in_base - GPIO_BASE_A;
    ch_ok     = (gpio_ch < GPIO_CH_A);
    in_xfer   = (state_q == XFER);
    last_beat = (k_q == LAST_K);
  end

  // Next-state and datapath: accept in IDLE, step beats in XFER, hold the result in RESP.
  always_comb begin
    // NOTE: every _d takes its _q value (or a safe constant) first, so that a path that
    // does not assign it holds state instead of inferring a latch.
    state_d   = state_q;
    base_d    = base_q;
    alu_d     = alu_q;
    sdata_d   = sdata_q;
    store_d   = store_q;
    k_d       = k_q;
    buf_d     = buf_q;
    res_d     = res_q;
    gpio_d    = gpio_q;
    gpio_en_d = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          base_d  = in_base;
          alu_d   = alu_res;
          sdata_d = store_data;
          // A store wins when both rmem and wmem are set.
          store_d = wmem;
          if (!rmem && !wmem) begin
            res_d   = alu_res;
            state_d = RESP;
          end else if (in_mmio) begin
            state_d = RESP;
            if (wmem) begin
              res_d = alu_res;
              // Channels past GPIO_CH are decoded as MMIO but write nothing.
              if (ch_ok) begin
                gpio_d    = store_data[GPIO_W-1:0];
                gpio_en_d = GPIO_CH'(1) << gpio_ch;
              end
            end else begin
              res_d = VEC_W'(gpio_q);
            end
          end else begin
            k_d     = '0;
            state_d = XFER;
          end
        end
      end

      XFER: begin
        if (mem_ack) begin
          if (!store_q) begin
            buf_d[k_q*BEAT_W +: BEAT_W] = mem_rdata;
          end
          if (last_beat) begin
            k_d     = '0;
            state_d = RESP;
            // buf_d already contains the final beat captured on this ack.
            res_d   = store_q ? alu_q : buf_d;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end

      RESP: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. An asynchronous reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      // NOTE: the beat buffer and latched operands are reset as well, so that the bus
      // outputs (derived from them) read zero during reset and simulation starts
      // without X values.
      base_q    <= '0;
      alu_q     <= '0;
      sdata_q   <= '0;
      store_q   <= 1'b0;
      k_q       <= '0;
      buf_q     <= '0;
      res_q     <= '0;
      gpio_q    <= '0;
      gpio_en_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the pre-edge values.
      state_q   <= state_d;
      base_q    <= base_d;
      alu_q     <= alu_d;
      sdata_q   <= sdata_d;
      store_q   <= store_d;
      k_q       <= k_d;
      buf_q     <= buf_d;
      res_q     <= res_d;
      gpio_q    <= gpio_d;
      gpio_en_q <= gpio_en_d;
    end
  end

  // Outputs come straight from state, so mem_req drops as soon as reset asserts.
  always_comb begin
    in_ready  = rst_n & (state_q == IDLE);
    out_valid = (state_q == RESP);
    res       = res_q;
    mem_req   = in_xfer;
    mem_we    = in_xfer & store_q;
    mem_addr  = in_xfer ? (base_q + ADDR_W'(k_q)) : '0;
    mem_wdata = in_xfer ? sdata_q[k_q*BEAT_W +: BEAT_W] : '0;
    gpio      = gpio_q;
    gpio_en   = gpio_en_q;
  end

endmodule
